// File: rtl/pit_pkg.sv
// ============================================================================
// pit_pkg : shared constants, FSM state types and helpers for pit_multi
// Revision: 1.0
// ============================================================================
`default_nettype none

package pit_pkg;

    localparam logic [1:0] C_REG_CTRL   = 2'd0;
    localparam logic [1:0] C_REG_PERIOD = 2'd1;
    localparam logic [1:0] C_REG_COUNT  = 2'd2;
    localparam logic [1:0] C_REG_STATUS = 2'd3;

    localparam int C_CTRL_EN       = 0;
    localparam int C_CTRL_PERIODIC = 1;
    localparam int C_CTRL_IE       = 2;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_ACCEPT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ACCEPT = 2'd1,
        RD_RESP   = 2'd2
    } rd_state_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] i_old,
                                               input logic [31:0] i_new,
                                               input logic [3:0]  i_strb);
        logic [31:0] w_res;
        for (int b = 0; b < 4; b++) begin
            w_res[8*b +: 8] = i_strb[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
        end
        return w_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pit_multi_if.sv
// ============================================================================
// pit_multi_if : AXI4-Lite bus bundle between a master and pit_multi
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pit_multi_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 6
);
    logic                          s_axi_awvalid;
    logic                          s_axi_awready;
    logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [2:0]                    s_axi_awprot;
    logic                          s_axi_wvalid;
    logic                          s_axi_wready;
    logic [31:0]                   s_axi_wdata;
    logic [3:0]                    s_axi_wstrb;
    logic                          s_axi_bvalid;
    logic                          s_axi_bready;
    logic [1:0]                    s_axi_bresp;
    logic                          s_axi_arvalid;
    logic                          s_axi_arready;
    logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [2:0]                    s_axi_arprot;
    logic                          s_axi_rvalid;
    logic                          s_axi_rready;
    logic [31:0]                   s_axi_rdata;
    logic [1:0]                    s_axi_rresp;

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        output s_axi_bready,
        output s_axi_arvalid, s_axi_araddr, s_axi_arprot,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        input  s_axi_bready,
        input  s_axi_arvalid, s_axi_araddr, s_axi_arprot,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );
endinterface

`default_nettype wire

// File: rtl/pit_channel.sv
// ============================================================================
// pit_channel : one down-counter channel with CTRL/PERIOD/COUNT/STATUS state
// Revision: 1.0
// ============================================================================
`default_nettype none

module pit_channel
    import pit_pkg::*;
#(
    parameter int C_COUNTER_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_wr_en,
    input  wire logic [1:0]  i_wr_off,
    input  wire logic [31:0] i_wr_data,
    input  wire logic [3:0]  i_wr_strb,
    input  wire logic [1:0]  i_rd_off,
    output logic      [31:0] o_rd_data,
    output logic             o_irq_src
);

    localparam logic [C_COUNTER_WIDTH-1:0] C_ONE = {{(C_COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic                       r_en, r_periodic, r_ie, r_pending;
    logic [C_COUNTER_WIDTH-1:0] r_period, r_count;

    logic                       w_en_nxt, w_periodic_nxt, w_ie_nxt, w_pending_nxt;
    logic [C_COUNTER_WIDTH-1:0] w_period_nxt, w_count_nxt;
    logic                       w_expire, w_clear;
    logic [31:0]                w_period_merged;
    logic                       w_unused;

    assign w_period_merged = strb_merge(32'(r_period), i_wr_data, i_wr_strb);
    assign w_unused        = ^w_period_merged;

    // The counter step is resolved first, then the software write is layered on
    // top, so a same-cycle EN=0 write still sees the expiry and a set beats W1C.
    always_comb begin
        w_en_nxt       = r_en;
        w_periodic_nxt = r_periodic;
        w_ie_nxt       = r_ie;
        w_period_nxt   = r_period;
        w_count_nxt    = r_count;
        w_expire       = 1'b0;
        w_clear        = 1'b0;

        if (r_en) begin
            if (r_count > C_ONE) begin
                w_count_nxt = r_count - C_ONE;
            end else begin
                w_expire = 1'b1;
                if (r_periodic) begin
                    w_count_nxt = r_period;
                end else begin
                    w_count_nxt = '0;
                    w_en_nxt    = 1'b0;
                end
            end
        end

        if (i_wr_en) begin
            case (i_wr_off)
                C_REG_CTRL: begin
                    if (i_wr_strb[0]) begin
                        if (!w_en_nxt && i_wr_data[C_CTRL_EN]) begin
                            w_count_nxt = r_period;
                        end
                        w_en_nxt       = i_wr_data[C_CTRL_EN];
                        w_periodic_nxt = i_wr_data[C_CTRL_PERIODIC];
                        w_ie_nxt       = i_wr_data[C_CTRL_IE];
                    end
                end
                C_REG_PERIOD: w_period_nxt = w_period_merged[C_COUNTER_WIDTH-1:0];
                C_REG_STATUS: w_clear      = i_wr_strb[0] & i_wr_data[0];
                default:      ;
            endcase
        end

        w_pending_nxt = w_expire | (r_pending & ~w_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_ie       <= 1'b0;
            r_pending  <= 1'b0;
            r_period   <= '0;
            r_count    <= '0;
        end else begin
            r_en       <= w_en_nxt;
            r_periodic <= w_periodic_nxt;
            r_ie       <= w_ie_nxt;
            r_pending  <= w_pending_nxt;
            r_period   <= w_period_nxt;
            r_count    <= w_count_nxt;
        end
    end

    always_comb begin
        o_rd_data = '0;
        case (i_rd_off)
            C_REG_CTRL:   o_rd_data = {29'd0, r_ie, r_periodic, r_en};
            C_REG_PERIOD: o_rd_data = 32'(r_period);
            C_REG_COUNT:  o_rd_data = 32'(r_count);
            C_REG_STATUS: o_rd_data = {31'd0, r_pending};
            default:      o_rd_data = '0;
        endcase
    end

    assign o_irq_src = r_pending & r_ie;

endmodule

`default_nettype wire

// File: rtl/pit_multi.sv
// ============================================================================
// pit_multi : multi-channel interval timer, AXI4-Lite slave, one level irq
// Revision: 1.0
// ============================================================================
`default_nettype none

module pit_multi
    import pit_pkg::*;
#(
    parameter int C_NUM_CHANNELS     = 4,
    parameter int C_COUNTER_WIDTH    = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  wire logic  s_axi_aclk,
    input  wire logic  s_axi_aresetn,
    pit_multi_if.slave axi,
    output logic       irq
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata, w_rd_mux;
    logic        r_irq;

    logic [AW-1:0] w_aw_idx, w_ar_idx;
    logic          w_aw_in_range, w_ar_in_range, w_wr_fire;

    logic [31:0]               w_ch_rd  [C_NUM_CHANNELS];
    logic [C_NUM_CHANNELS-1:0] w_ch_wr_en;
    logic [C_NUM_CHANNELS-1:0] w_irq_src;
    logic                      w_unused;

    assign w_unused = ^{axi.s_axi_awprot, axi.s_axi_arprot,
                        axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};

    assign w_aw_idx      = axi.s_axi_awaddr >> 4;
    assign w_ar_idx      = axi.s_axi_araddr >> 4;
    assign w_aw_in_range = (w_aw_idx < AW'(C_NUM_CHANNELS));
    assign w_ar_in_range = (w_ar_idx < AW'(C_NUM_CHANNELS));
    assign w_wr_fire     = (r_wr_state == WR_ACCEPT);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt    = r_wr_state;
        axi.s_axi_awready = 1'b0;
        axi.s_axi_wready  = 1'b0;
        axi.s_axi_bvalid  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (axi.s_axi_awvalid && axi.s_axi_wvalid) w_wr_state_nxt = WR_ACCEPT;
            end
            WR_ACCEPT: begin
                axi.s_axi_awready = 1'b1;
                axi.s_axi_wready  = 1'b1;
                w_wr_state_nxt    = WR_RESP;
            end
            WR_RESP: begin
                axi.s_axi_bvalid = 1'b1;
                if (axi.s_axi_bready) w_wr_state_nxt = WR_IDLE;
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_nxt    = r_rd_state;
        axi.s_axi_arready = 1'b0;
        axi.s_axi_rvalid  = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (axi.s_axi_arvalid) w_rd_state_nxt = RD_ACCEPT;
            end
            RD_ACCEPT: begin
                axi.s_axi_arready = 1'b1;
                w_rd_state_nxt    = RD_RESP;
            end
            RD_RESP: begin
                axi.s_axi_rvalid = 1'b1;
                if (axi.s_axi_rready) w_rd_state_nxt = RD_IDLE;
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Read data is captured on the same edge a concurrent write commits,
    // so a colliding read returns the pre-write value.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_bresp <= C_RESP_OKAY;
            r_rresp <= C_RESP_OKAY;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_bresp <= w_aw_in_range ? C_RESP_OKAY : C_RESP_SLVERR;
            end
            if (r_rd_state == RD_ACCEPT) begin
                r_rresp <= w_ar_in_range ? C_RESP_OKAY : C_RESP_SLVERR;
                r_rdata <= w_rd_mux;
            end
            r_irq <= |w_irq_src;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < C_NUM_CHANNELS; c++) begin
            if (w_ar_idx == AW'(c)) w_rd_mux = w_ch_rd[c];
        end
    end

    generate
        for (genvar c = 0; c < C_NUM_CHANNELS; c++) begin : g_ch
            assign w_ch_wr_en[c] = w_wr_fire && (w_aw_idx == AW'(c));

            pit_channel #(
                .C_COUNTER_WIDTH (C_COUNTER_WIDTH)
            ) u_channel (
                .clk       (s_axi_aclk),
                .rst_n     (s_axi_aresetn),
                .i_wr_en   (w_ch_wr_en[c]),
                .i_wr_off  (axi.s_axi_awaddr[3:2]),
                .i_wr_data (axi.s_axi_wdata),
                .i_wr_strb (axi.s_axi_wstrb),
                .i_rd_off  (axi.s_axi_araddr[3:2]),
                .o_rd_data (w_ch_rd[c]),
                .o_irq_src (w_irq_src[c])
            );
        end
    endgenerate

    assign axi.s_axi_bresp = r_bresp;
    assign axi.s_axi_rresp = r_rresp;
    assign axi.s_axi_rdata = r_rdata;
    assign irq             = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_pit_multi.sv
// ============================================================================
// tb_pit_multi : directed + randomized bench for pit_multi with a cycle model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pit_multi;
    import pit_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int AW  = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    always #5 clk = ~clk;

    pit_multi_if #(.C_S_AXI_ADDR_WIDTH(AW)) axi ();

    pit_multi #(
        .C_NUM_CHANNELS     (NCH),
        .C_COUNTER_WIDTH    (CW),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) u_dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .axi           (axi.slave),
        .irq           (irq)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: timer state as plain arrays, advanced once per clock.
    logic        m_en     [NCH];
    logic        m_per    [NCH];
    logic        m_ie     [NCH];
    logic        m_pend   [NCH];
    logic [31:0] m_period [NCH];
    logic [31:0] m_cnt    [NCH];
    logic        m_irq    = 1'b0;
    logic [31:0] m_rd_exp = '0;
    logic        m_run    = 1'b0;

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        int idx;
        logic [1:0] off;
        idx = int'(a >> 4);
        off = a[3:2];
        if (idx >= NCH) return 32'd0;
        case (off)
            2'd0:    return {29'd0, m_ie[idx], m_per[idx], m_en[idx]};
            2'd1:    return m_period[idx];
            2'd2:    return m_cnt[idx];
            default: return {31'd0, m_pend[idx]};
        endcase
    endfunction

    initial begin : model
        logic        irq_nxt;
        logic        expd [NCH];
        int          widx;
        logic [31:0] wd;
        logic [3:0]  ws;
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
            m_period[c] = 0; m_cnt[c] = 0;
        end
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (axi.s_axi_arvalid && axi.s_axi_arready) m_rd_exp = model_read(axi.s_axi_araddr);
                irq_nxt = 1'b0;
                for (int c = 0; c < NCH; c++) irq_nxt |= m_pend[c] & m_ie[c];
                for (int c = 0; c < NCH; c++) begin
                    expd[c] = 1'b0;
                    if (m_en[c]) begin
                        if (m_cnt[c] > 1) m_cnt[c] = m_cnt[c] - 1;
                        else begin
                            m_pend[c] = 1'b1;
                            expd[c]   = 1'b1;
                            if (m_per[c]) m_cnt[c] = m_period[c];
                            else begin m_cnt[c] = 0; m_en[c] = 0; end
                        end
                    end
                end
                if (axi.s_axi_awvalid && axi.s_axi_awready) begin
                    widx = int'(axi.s_axi_awaddr >> 4);
                    wd   = axi.s_axi_wdata;
                    ws   = axi.s_axi_wstrb;
                    if (widx < NCH) begin
                        case (axi.s_axi_awaddr[3:2])
                            2'd0: if (ws[0]) begin
                                if (!m_en[widx] && wd[0]) m_cnt[widx] = m_period[widx];
                                m_en[widx]  = wd[0];
                                m_per[widx] = wd[1];
                                m_ie[widx]  = wd[2];
                            end
                            2'd1: for (int b = 0; b < 4; b++)
                                if (ws[b]) m_period[widx][8*b +: 8] = wd[8*b +: 8];
                            2'd3: if (ws[0] && wd[0] && !expd[widx]) m_pend[widx] = 1'b0;
                            default: ;
                        endcase
                    end
                end
                m_irq = irq_nxt;
            end
        end
    end

    initial begin : irq_monitor
        forever begin
            @(negedge clk);
            if (m_run) check_val("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int hold);
        int n;
        logic [1:0] exp_resp;
        exp_resp = (int'(a >> 4) >= NCH) ? C_RESP_SLVERR : C_RESP_OKAY;
        axi.s_axi_awaddr  = a;
        axi.s_axi_wdata   = d;
        axi.s_axi_wstrb   = s;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.s_axi_awready && n < 16);
        if (!axi.s_axi_awready) begin
            check_val("aw_timeout", 32'd0, 32'd1);
            axi.s_axi_awvalid = 1'b0;
            axi.s_axi_wvalid  = 1'b0;
            return;
        end
        check_val("wready", {31'd0, axi.s_axi_wready}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            check_val("bvalid_hold", {31'd0, axi.s_axi_bvalid}, 32'd1);
            check_val("no_2nd_accept", {31'd0, axi.s_axi_awready}, 32'd0);
            @(negedge clk);
        end
        check_val("bvalid", {31'd0, axi.s_axi_bvalid}, 32'd1);
        check_val($sformatf("bresp@%02h", a), {30'd0, axi.s_axi_bresp}, {30'd0, exp_resp});
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        axi.s_axi_bready  = 1'b1;
        @(negedge clk);
        axi.s_axi_bready  = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int hold, output logic [31:0] d);
        int n;
        logic [1:0] exp_resp;
        exp_resp = (int'(a >> 4) >= NCH) ? C_RESP_SLVERR : C_RESP_OKAY;
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.s_axi_arready && n < 16);
        if (!axi.s_axi_arready) begin
            check_val("ar_timeout", 32'd0, 32'd1);
            axi.s_axi_arvalid = 1'b0;
            d = '0;
            return;
        end
        @(negedge clk);
        axi.s_axi_arvalid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check_val("rvalid_hold", {31'd0, axi.s_axi_rvalid}, 32'd1);
            @(negedge clk);
        end
        check_val("rvalid", {31'd0, axi.s_axi_rvalid}, 32'd1);
        check_val($sformatf("rdata@%02h", a), axi.s_axi_rdata, m_rd_exp);
        check_val($sformatf("rresp@%02h", a), {30'd0, axi.s_axi_rresp}, {30'd0, exp_resp});
        d = axi.s_axi_rdata;
        axi.s_axi_rready = 1'b1;
        @(negedge clk);
        axi.s_axi_rready = 1'b0;
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] d, d2;
        logic [AW-1:0] a;
        int n, c, r;

        axi.s_axi_awvalid = 0; axi.s_axi_awaddr = '0; axi.s_axi_awprot = '0;
        axi.s_axi_wvalid  = 0; axi.s_axi_wdata  = '0; axi.s_axi_wstrb  = '0;
        axi.s_axi_bready  = 0;
        axi.s_axi_arvalid = 0; axi.s_axi_araddr = '0; axi.s_axi_arprot = '0;
        axi.s_axi_rready  = 0;

        repeat (3) @(negedge clk);
        check_val("rst_irq",     {31'd0, irq}, 32'd0);
        check_val("rst_bvalid",  {31'd0, axi.s_axi_bvalid}, 32'd0);
        check_val("rst_rvalid",  {31'd0, axi.s_axi_rvalid}, 32'd0);
        check_val("rst_awready", {31'd0, axi.s_axi_awready}, 32'd0);
        check_val("rst_arready", {31'd0, axi.s_axi_arready}, 32'd0);
        check_val("rst_rdata",   axi.s_axi_rdata, 32'd0);
        rst_n = 1'b1;
        m_run = 1'b1;

        for (int ch = 0; ch < NCH; ch++)
            for (int rg = 0; rg < 4; rg++) begin
                axi_read(AW'(ch * 16 + rg * 4), 0, d);
                check_val("rst_reg", d, 32'd0);
            end

        // Out-of-range channel: SLVERR, read data 0, no side effects.
        axi_write(7'h40, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(7'h44, 32'h0000_0010, 4'hF, 0);
        axi_read(7'h40, 0, d); check_val("oor_rdata", d, 32'd0);
        axi_read(7'h44, 1, d); check_val("oor_rdata", d, 32'd0);

        // Byte-strobed PERIOD write, response held off for 4 cycles.
        axi_write(7'h24, 32'hFFFF_FFFF, 4'b0001, 4);
        axi_read(7'h24, 0, d); check_val("period_strb", d, 32'h0000_00FF);

        axi_write(7'h04, 32'd5, 4'hF, 0);
        axi_write(7'h00, 32'h7, 4'hF, 0);
        repeat (12) @(negedge clk);
        axi_read(7'h0C, 0, d); check_val("ch0_pending", d, 32'd1);
        axi_write(7'h0C, 32'd1, 4'hF, 0);
        repeat (3) @(negedge clk);

        n = 0;
        while (!(m_pend[0] && m_cnt[0] == 32'd2) && n < 50) begin @(negedge clk); n++; end
        check_val("w1c_align", {31'd0, (m_pend[0] && m_cnt[0] == 32'd2)}, 32'd1);
        axi_write(7'h0C, 32'd1, 4'hF, 0);
        axi_read(7'h0C, 0, d); check_val("w1c_set_wins", d, 32'd1);

        axi_write(7'h00, 32'h0, 4'hF, 0);
        axi_write(7'h0C, 32'd1, 4'hF, 0);
        axi_write(7'h14, 32'd3, 4'hF, 0);
        axi_write(7'h10, 32'h1, 4'hF, 0);
        repeat (8) @(negedge clk);
        axi_read(7'h10, 0, d); check_val("oneshot_en", d, 32'd0);
        axi_read(7'h18, 0, d); check_val("oneshot_count", d, 32'd0);
        axi_read(7'h1C, 0, d); check_val("oneshot_pending", d, 32'd1);
        check_val("oneshot_irq", {31'd0, irq}, 32'd0);

        for (int it = 0; it < 300; it++) begin
            c = $urandom_range(0, NCH);
            r = $urandom_range(0, 3);
            a = AW'(c * 16 + r * 4 + int'($urandom_range(0, 3)));
            case (r)
                1:       d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 9));
                default: d = $urandom;
            endcase
            n = $urandom_range(0, 9);
            if (n < 4) axi_read(a, $urandom_range(0, 2), d2);
            else if (n == 9) begin
                fork
                    axi_write(a, d, 4'hF, 0);
                    axi_read(a, 0, d2);
                join
            end else
                axi_write(a, d, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                          $urandom_range(0, 2));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
